// File: rtl/imu_reader.sv
// rtl/imu_reader.sv - burst-read sequencer from frame trigger to IMU SPI byte master
// Reads NUM_WORDS big-endian words per trigger and publishes them atomically.
module imu_reader #(
  parameter logic [7:0] START_ADDR = 8'h3B,
  parameter int         NUM_WORDS  = 7,
  parameter int         SS_SETUP   = 4,
  parameter int         SS_HOLD    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trigger,
  output logic                     spi_start,
  output logic [7:0]               spi_data_in,
  input  logic                     spi_busy,
  input  logic                     spi_new_data,
  input  logic [7:0]               spi_data_out,
  output logic                     imu_ss,
  output logic [16*NUM_WORDS-1:0]  imu_data,
  output logic                     sample_valid,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int NBYTES  = 2 * NUM_WORDS;
  localparam int IDXW    = $clog2(NBYTES);
  localparam int CNT_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NBYTES - 1);
  localparam logic [CNTW-1:0] SETUP_LAST = CNTW'(SS_SETUP - 1);
  localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'(SS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ADDR, READ, HOLD} state_t;

  state_t                  state, state_d;
  logic [CNTW-1:0]         cnt, cnt_d;
  logic [IDXW-1:0]         idx, idx_d;
  logic                    launched, launched_d;
  logic [16*NUM_WORDS-1:0] shadow, shadow_d, imu_data_d;
  logic [7:0]              spi_data_in_d;
  logic                    spi_start_d, imu_ss_d, sample_valid_d, overrun_d;

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    idx_d          = idx;
    launched_d     = launched;
    shadow_d       = shadow;
    imu_data_d     = imu_data;
    spi_data_in_d  = spi_data_in;
    spi_start_d    = 1'b0;
    imu_ss_d       = imu_ss;
    sample_valid_d = 1'b0;
    overrun_d      = overrun;

    // a new overrun takes priority over a same-cycle clear
    if (trigger && state != IDLE) overrun_d = 1'b1;
    else if (overrun_clr)         overrun_d = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_d  = SETUP;
          cnt_d    = '0;
          imu_ss_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_d       = ADDR;
          cnt_d         = '0;
          spi_data_in_d = START_ADDR | 8'h80;
          launched_d    = !spi_busy;
          spi_start_d   = !spi_busy;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ADDR: begin
        if (spi_new_data) begin
          state_d       = READ;
          idx_d         = '0;
          launched_d    = 1'b0;
          spi_data_in_d = 8'hFF;
        end else if (!launched && !spi_busy) begin
          spi_start_d = 1'b1;
          launched_d  = 1'b1;
        end
      end
      READ: begin
        if (spi_new_data) begin
          // even byte index is the high byte of its word
          for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDXW'(k)) shadow_d[8*(k^1) +: 8] = spi_data_out;
          end
          launched_d = 1'b0;
          if (idx == LAST_IDX) begin
            imu_data_d     = shadow_d;
            sample_valid_d = 1'b1;
            imu_ss_d       = 1'b1;
            state_d        = HOLD;
            cnt_d          = '0;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else if (!launched && !spi_busy) begin
          spi_start_d = 1'b1;
          launched_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      launched     <= 1'b0;
      shadow       <= '0;
      imu_data     <= '0;
      spi_data_in  <= 8'hFF;
      spi_start    <= 1'b0;
      imu_ss       <= 1'b1;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      launched     <= launched_d;
      shadow       <= shadow_d;
      imu_data     <= imu_data_d;
      spi_data_in  <= spi_data_in_d;
      spi_start    <= spi_start_d;
      imu_ss       <= imu_ss_d;
      sample_valid <= sample_valid_d;
      overrun      <= overrun_d;
    end
  end

endmodule

// File: tb/tb_imu_reader.sv
// tb/tb_imu_reader.sv - randomized self-checking bench for imu_reader
// SPI slave model returns per-burst byte tables; expected words come from those tables.
module tb_imu_reader;

  localparam int         NW    = 7;
  localparam int         NB    = 2 * NW;
  localparam int         SETUP = 4;
  localparam int         HOLD  = 8;
  localparam logic [7:0] SADDR = 8'h3B;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            trigger = 1'b0;
  logic            spi_busy;
  logic            spi_new_data = 1'b0;
  logic [7:0]      spi_data_out = 8'h00;
  logic            overrun_clr = 1'b0;
  logic            force_busy = 1'b0;
  logic            sl_busy = 1'b0;
  logic            spi_start;
  logic [7:0]      spi_data_in;
  logic            imu_ss;
  logic [16*NW-1:0] imu_data;
  logic            sample_valid;
  logic            overrun;

  assign spi_busy = sl_busy | force_busy;

  imu_reader #(
    .START_ADDR(SADDR), .NUM_WORDS(NW), .SS_SETUP(SETUP), .SS_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger),
    .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data), .spi_data_out(spi_data_out),
    .imu_ss(imu_ss), .imu_data(imu_data), .sample_valid(sample_valid),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0]       bytes [0:15];
  logic [16*NW-1:0] exp_data;
  logic [16*NW-1:0] prev;

  int xfer = 0, sl_cnt = 0;
  int starts = 0, bad_din = 0, start_busy = 0, svs = 0, glitches = 0;
  int ss_fall_cyc = 0, ss_rise_cyc = 0, last_hi = 0, last_setup = 0;
  int last_nd_cyc = 0, last_sv_lat = 0, first_start_cyc = 0;
  logic             ss_q = 1'b1;
  logic [16*NW-1:0] data_q = '0;

  // SPI slave model and bus monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sl_busy = 1'b0;
        spi_new_data = 1'b0;
        xfer = 0;
        if (!ss_q) ss_rise_cyc = cyc;
        ss_q = 1'b1;
        data_q = imu_data;
      end else begin
        spi_new_data = 1'b0;
        if (imu_ss && !ss_q) ss_rise_cyc = cyc;
        if (!imu_ss && ss_q) begin
          ss_fall_cyc = cyc;
          last_hi = cyc - ss_rise_cyc;
        end
        ss_q = imu_ss;
        if (imu_ss) xfer = 0;
        if (sample_valid) begin
          svs++;
          last_sv_lat = cyc - last_nd_cyc;
        end else if (imu_data !== data_q) begin
          glitches++;
        end
        data_q = imu_data;
        if (spi_start) begin
          starts++;
          if (sl_busy || force_busy) start_busy++;
          if (xfer == 0) begin
            first_start_cyc = cyc;
            last_setup = cyc - ss_fall_cyc;
            if (spi_data_in !== (SADDR | 8'h80)) bad_din++;
          end else if (spi_data_in !== 8'hFF) begin
            bad_din++;
          end
          sl_busy = 1'b1;
          sl_cnt = $urandom_range(1, 4);
        end else if (sl_busy) begin
          if (sl_cnt == 0) begin
            spi_new_data = 1'b1;
            spi_data_out = bytes[4'(xfer)];
            xfer++;
            sl_busy = 1'b0;
            last_nd_cyc = cyc;
          end else begin
            sl_cnt--;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check_i(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_v(input string tag, input logic [16*NW-1:0] obs, input logic [16*NW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // byte 0 answers the address phase and is discarded; words are big-endian pairs after it
  task automatic load_bytes(input bit seq);
    for (int i = 0; i < 16; i++) bytes[4'(i)] = seq ? 8'(i) : 8'($urandom);
    exp_data = '0;
    for (int k = NW - 1; k >= 0; k--)
      exp_data = {exp_data[16*NW-17:0], bytes[4'(2*k+1)], bytes[4'(2*k+2)]};
  endtask

  task automatic wait_sv(input string tag, input logic [16*NW-1:0] hold_val, input bit hammer);
    int n0 = svs;
    int k = 0;
    int held_bad = 0;
    while (svs == n0 && k < 2000) begin
      if (imu_data !== hold_val) held_bad++;
      if (hammer) trigger = 1'b1;
      tick();
      k++;
    end
    trigger = 1'b0;
    check_i({tag, "_sv_seen"}, int'(k < 2000), 1);
    check_i({tag, "_data_held"}, held_bad, 0);
  endtask

  initial begin
    int s0, v0, r, rel_cyc;
    repeat (3) @(negedge clk);
    #2;
    check_i("rst_ss", int'(imu_ss), 1);
    check_i("rst_start", int'(spi_start), 0);
    check_i("rst_din", int'(spi_data_in), 8'hFF);
    check_v("rst_data", imu_data, '0);
    check_i("rst_sv", int'(sample_valid), 0);
    check_i("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // A: sequential bytes 0x01..0x0E
    load_bytes(1'b1);
    prev = '0;
    s0 = starts; v0 = svs;
    trigger = 1'b1; tick(); trigger = 1'b0;
    check_i("a_ss_low", int'(imu_ss), 0);
    wait_sv("a", prev, 1'b0);
    check_v("a_data", imu_data, exp_data);
    check_i("a_sv_lat", last_sv_lat, 1);
    check_i("a_ss_rise", int'(imu_ss), 1);
    check_i("a_setup", last_setup, SETUP);
    repeat (HOLD + 2) tick();
    check_i("a_starts", starts - s0, NB + 1);
    check_i("a_svs", svs - v0, 1);
    prev = exp_data;

    // B then C back to back
    load_bytes(1'b0);
    v0 = svs;
    trigger = 1'b1; tick(); trigger = 1'b0;
    wait_sv("b", prev, 1'b0);
    check_v("b_data", imu_data, exp_data);
    prev = exp_data;
    load_bytes(1'b0);
    s0 = starts;
    trigger = 1'b1;
    r = 0;
    while (imu_ss && r < 50) begin tick(); r++; end
    trigger = 1'b0;
    check_i("c_hold_gap", last_hi, HOLD + 1);
    wait_sv("c", prev, 1'b0);
    check_v("c_data", imu_data, exp_data);
    check_i("c_setup", last_setup, SETUP);
    repeat (HOLD + 2) tick();
    check_i("c_starts", starts - s0, NB + 1);
    check_i("bc_svs", svs - v0, 2);
    prev = exp_data;
    check_i("ovr_from_hold", int'(overrun), 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check_i("ovr_clr", int'(overrun), 0);

    // D: trigger held every cycle through the burst
    load_bytes(1'b0);
    s0 = starts; v0 = svs;
    trigger = 1'b1; tick();
    check_i("d_ovr_accept", int'(overrun), 0);
    tick();
    check_i("d_ovr_set", int'(overrun), 1);
    wait_sv("d", prev, 1'b1);
    check_v("d_data", imu_data, exp_data);
    repeat (HOLD + 2) tick();
    check_i("d_starts", starts - s0, NB + 1);
    check_i("d_svs", svs - v0, 1);
    prev = exp_data;

    // E: clear and new overrun in the same cycle
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check_i("e_ovr_clr", int'(overrun), 0);
    load_bytes(1'b0);
    trigger = 1'b1; tick();
    overrun_clr = 1'b1; tick();
    trigger = 1'b0; overrun_clr = 1'b0;
    check_i("e_set_wins", int'(overrun), 1);
    wait_sv("e", prev, 1'b0);
    check_v("e_data", imu_data, exp_data);
    repeat (HOLD + 2) tick();
    prev = exp_data;

    // F: reset after the fifth data byte
    load_bytes(1'b0);
    v0 = svs;
    trigger = 1'b1; tick(); trigger = 1'b0;
    r = 0;
    while (xfer < 6 && r < 500) begin tick(); r++; end
    check_i("f_reach_byte5", int'(r < 500), 1);
    rst_n = 1'b0;
    #1;
    check_i("f_rst_ss", int'(imu_ss), 1);
    check_v("f_rst_data", imu_data, '0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_i("f_no_sv", svs - v0, 0);
    check_i("f_ss_idle", int'(imu_ss), 1);
    prev = '0;

    // G: clean burst after reset
    load_bytes(1'b0);
    s0 = starts; v0 = svs;
    trigger = 1'b1; tick(); trigger = 1'b0;
    wait_sv("g", prev, 1'b0);
    check_v("g_data", imu_data, exp_data);
    check_i("g_setup", last_setup, SETUP);
    repeat (HOLD + 2) tick();
    check_i("g_starts", starts - s0, NB + 1);
    check_i("g_svs", svs - v0, 1);
    prev = exp_data;

    // H: SPI master busy across the end of setup
    load_bytes(1'b0);
    force_busy = 1'b1;
    s0 = starts; v0 = svs;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (SETUP + 20) tick();
    check_i("h_no_start", starts - s0, 0);
    force_busy = 1'b0;
    rel_cyc = cyc;
    wait_sv("h", prev, 1'b0);
    check_i("h_first_start", first_start_cyc, rel_cyc + 1);
    check_v("h_data", imu_data, exp_data);
    repeat (HOLD + 2) tick();
    check_i("h_starts", starts - s0, NB + 1);
    check_i("h_svs", svs - v0, 1);

    check_i("glitches", glitches, 0);
    check_i("bad_din", bad_din, 0);
    check_i("start_while_busy", start_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
